// File: rtl/depth_test_writer_pkg.sv
// Shared types for the depth-test / framebuffer write path.
//   q16_16_t      signed 16.16 fixed-point depth (smaller = nearer)
//   color12_t     4:4:4 pixel colour
//   fb_addr_t     linear pixel address for the default 320x240 screen
//   pixel_stage_t one pipeline slot: address, depth, colour, compare flag, clip flag
//   last_write_t  the z-buffer write committed in the previous cycle (forwarding)
package depth_test_writer_pkg;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 240;
  localparam int FB_ADDR_W     = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);

  localparam int                STAT_W   = 32;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  typedef logic signed [31:0]    q16_16_t;
  typedef logic [11:0]           color12_t;
  typedef logic [FB_ADDR_W-1:0]  fb_addr_t;

  typedef struct packed {
    fb_addr_t addr;
    q16_16_t  depth;
    color12_t color;
    logic     compare;
    logic     clip;
  } pixel_stage_t;

  typedef struct packed {
    logic     valid;
    fb_addr_t addr;
    q16_16_t  depth;
  } last_write_t;

  // Row-major linear address, truncated to the framebuffer address width.
  function automatic fb_addr_t pixel_addr(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic [31:0] width);
    return fb_addr_t'({16'd0, y} * width + {16'd0, x});
  endfunction

endpackage

// File: rtl/pixel_stats_counters.sv
// Saturating pixel-outcome counters for the depth-test writer.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   stat_clear     zeroes all counters; wins over a same-cycle increment
//   inc_written    one framebuffer handshake this cycle
//   inc_rejected   one compare-failed pixel left stage B this cycle
//   inc_clipped    one clipped pixel left stage B this cycle
//   stat_written, stat_rejected, stat_clipped   counter values
module pixel_stats_counters
  import depth_test_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stat_clear,
  input  logic              inc_written,
  input  logic              inc_rejected,
  input  logic              inc_clipped,
  output logic [STAT_W-1:0] stat_written,
  output logic [STAT_W-1:0] stat_rejected,
  output logic [STAT_W-1:0] stat_clipped
);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value,
                                                 input logic              inc);
    return (inc && value != STAT_MAX) ? value + 1'b1 : value;
  endfunction

  // Counters stick at all-ones instead of wrapping so a long run never
  // reports a misleadingly small number.
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_written  <= '0;
      stat_rejected <= '0;
      stat_clipped  <= '0;
    end else begin
      stat_written  <= sat_inc(stat_written,  inc_written);
      stat_rejected <= sat_inc(stat_rejected, inc_rejected);
      stat_clipped  <= sat_inc(stat_clipped,  inc_clipped);
    end
  end

endmodule

// File: rtl/depth_test_writer.sv
// Depth-test writer: two-stage read-modify-write of the z-buffer for the
// render manager's pixel stream, committing surviving pixels to the z-buffer
// and the framebuffer write port.
//   Stage A: computes/holds address and clip flag, issues the z-buffer read.
//   Stage B: compares against the read (or forwarded) depth and writes.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_pixel_x/y, in_depth,
//   in_color, in_compare_depth,
//   in_valid / in_ready             incoming pixel handshake
//   zb_rd_en/addr, zb_rd_data       z-buffer read port (1-cycle latency)
//   zb_wr_en/addr/data              z-buffer write port
//   fb_wr_valid/ready/addr/color    framebuffer write handshake
//   busy                            a pixel is in flight
// Optional build macro PIXEL_STATS_EN adds stat_clear input and the
// stat_written / stat_rejected / stat_clipped counter outputs.
module depth_test_writer
  import depth_test_writer_pkg::*;
#(
  parameter  int WIDTH  = 320,
  parameter  int HEIGHT = 240,
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in_pixel_x,
  input  logic [15:0]       in_pixel_y,
  input  logic [31:0]       in_depth,
  input  logic [11:0]       in_color,
  input  logic              in_compare_depth,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              zb_rd_en,
  output logic [ADDR_W-1:0] zb_rd_addr,
  input  logic [31:0]       zb_rd_data,
  output logic              zb_wr_en,
  output logic [ADDR_W-1:0] zb_wr_addr,
  output logic [31:0]       zb_wr_data,
  output logic              fb_wr_valid,
  input  logic              fb_wr_ready,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [11:0]       fb_wr_color,
  output logic              busy
`ifdef PIXEL_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [31:0]       stat_written,
  output logic [31:0]       stat_rejected,
  output logic [31:0]       stat_clipped
`endif
);

  pixel_stage_t a_stage, b_stage;
  logic         a_valid, b_valid;
  logic         b_hold;
  last_write_t  last_wr;

  logic         in_clip;
  logic         accept;
  q16_16_t      stored;
  logic         depth_ok;
  logic         pass;
  logic         stall;
  logic         commit;

  // Clip, handshake and the depth decision for the pixel sitting in B.
  // b_hold keeps a stalled pixel's pass decision: while stalled, the read
  // port serves A's address, so zb_rd_data no longer belongs to B.
  always_comb begin
    in_clip  = ({16'd0, in_pixel_x} >= 32'(WIDTH)) |
               ({16'd0, in_pixel_y} >= 32'(HEIGHT));
    stored   = (last_wr.valid && last_wr.addr == b_stage.addr) ?
               last_wr.depth : $signed(zb_rd_data);
    depth_ok = !b_stage.compare || ($signed(b_stage.depth) < $signed(stored));
    pass     = !rst && b_valid && !b_stage.clip && (b_hold || depth_ok);
    stall    = pass && !fb_wr_ready;
    commit   = pass && fb_wr_ready;
    in_ready = !rst && (!a_valid || !stall);
    accept   = in_valid && in_ready;
  end

  // Pipeline registers. A advances into B whenever B is not stalled; A is
  // refilled on accept, otherwise emptied once its pixel has moved on.
  // last_wr remembers only the previous cycle's commit because the memory
  // is read-before-write: older writes are already visible in zb_rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      b_hold  <= 1'b0;
      a_stage <= '0;
      b_stage <= '0;
      last_wr <= '0;
    end else begin
      last_wr <= '{valid: commit, addr: b_stage.addr, depth: b_stage.depth};
      b_hold  <= stall;
      if (!stall) begin
        b_valid <= a_valid;
        b_stage <= a_stage;
      end
      if (accept) begin
        a_valid <= 1'b1;
        a_stage <= '{addr:    pixel_addr(in_pixel_x, in_pixel_y, 32'(WIDTH)),
                     depth:   $signed(in_depth),
                     color:   in_color,
                     compare: in_compare_depth,
                     clip:    in_clip};
      end else if (!stall) begin
        a_valid <= 1'b0;
      end
    end
  end

  // Memory-facing outputs, forced to zero while reset is asserted.
  always_comb begin
    zb_rd_en    = !rst && a_valid && !a_stage.clip;
    zb_rd_addr  = rst ? '0 : ADDR_W'(a_stage.addr);
    zb_wr_en    = commit;
    zb_wr_addr  = rst ? '0 : ADDR_W'(b_stage.addr);
    zb_wr_data  = rst ? '0 : b_stage.depth;
    fb_wr_valid = pass;
    fb_wr_addr  = rst ? '0 : ADDR_W'(b_stage.addr);
    fb_wr_color = rst ? '0 : b_stage.color;
    busy        = !rst && (a_valid || b_valid);
  end

`ifdef PIXEL_STATS_EN
  logic        reject_event;
  logic        clip_event;
  logic [31:0] cnt_written, cnt_rejected, cnt_clipped;

  // A held pixel has already passed, so it can never count as a reject.
  always_comb begin
    reject_event  = !rst && b_valid && !b_stage.clip && !b_hold && !depth_ok;
    clip_event    = !rst && b_valid && b_stage.clip;
    stat_written  = rst ? '0 : cnt_written;
    stat_rejected = rst ? '0 : cnt_rejected;
    stat_clipped  = rst ? '0 : cnt_clipped;
  end

  pixel_stats_counters u_stats (
    .clk           (clk),
    .rst           (rst),
    .stat_clear    (stat_clear),
    .inc_written   (commit),
    .inc_rejected  (reject_event),
    .inc_clipped   (clip_event),
    .stat_written  (cnt_written),
    .stat_rejected (cnt_rejected),
    .stat_clipped  (cnt_clipped)
  );
`endif

endmodule

// File: tb/tb_depth_test_writer.sv
// Self-checking bench for depth_test_writer: a z-buffer memory model on the
// read/write ports, an in-order pixel reference model that decides which
// accepted pixels must reach the framebuffer, directed cases and a
// randomized phase.
module tb_depth_test_writer;
  import depth_test_writer_pkg::*;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   in_pixel_x, in_pixel_y;
  logic [31:0]   in_depth;
  logic [11:0]   in_color;
  logic          in_compare_depth, in_valid, in_ready;
  logic          zb_rd_en, zb_wr_en;
  logic [AW-1:0] zb_rd_addr, zb_wr_addr, fb_wr_addr;
  logic [31:0]   zb_rd_data = '0;
  logic [31:0]   zb_wr_data;
  logic          fb_wr_valid, fb_wr_ready;
  logic [11:0]   fb_wr_color;
  logic          busy;
`ifdef PIXEL_STATS_EN
  logic          stat_clear;
  logic [31:0]   stat_written, stat_rejected, stat_clipped;
`endif

  always #5 clk = ~clk;

  depth_test_writer dut (
    .clk              (clk),
    .rst              (rst),
    .in_pixel_x       (in_pixel_x),
    .in_pixel_y       (in_pixel_y),
    .in_depth         (in_depth),
    .in_color         (in_color),
    .in_compare_depth (in_compare_depth),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .zb_rd_en         (zb_rd_en),
    .zb_rd_addr       (zb_rd_addr),
    .zb_rd_data       (zb_rd_data),
    .zb_wr_en         (zb_wr_en),
    .zb_wr_addr       (zb_wr_addr),
    .zb_wr_data       (zb_wr_data),
    .fb_wr_valid      (fb_wr_valid),
    .fb_wr_ready      (fb_wr_ready),
    .fb_wr_addr       (fb_wr_addr),
    .fb_wr_color      (fb_wr_color),
    .busy             (busy)
`ifdef PIXEL_STATS_EN
    ,
    .stat_clear       (stat_clear),
    .stat_written     (stat_written),
    .stat_rejected    (stat_rejected),
    .stat_clipped     (stat_clipped)
`endif
  );

  // Z-buffer memory: one-cycle read latency, read-before-write.
  logic [31:0] zb_mem  [0:W*H-1];
  logic [31:0] model_z [0:W*H-1];

  always @(posedge clk) begin
    if (zb_rd_en) zb_rd_data <= zb_mem[zb_rd_addr];
    if (zb_wr_en) zb_mem[zb_wr_addr] <= zb_wr_data;
  end

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] depth;
    logic [11:0] color;
    logic        compare;
  } px_t;

  px_t         pend[$];
  int          pass_cnt = 0;
  int          check_cnt = 0;
  int          hs_count = 0;
  logic [31:0] last_hs_addr, last_hs_depth;
  int          model_written = 0, model_rejected = 0, model_clipped = 0;
  bit          mon_en = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
  endtask

  // Pixels resolve strictly in acceptance order: clipped and losing pixels
  // vanish, the next surviving pixel is the next framebuffer write.
  task automatic model_next_write(output bit found, output logic [31:0] addr,
                                  output logic [31:0] depth, output logic [11:0] color);
    found = 0;
    addr  = '0;
    depth = '0;
    color = '0;
    while (!found && pend.size() > 0) begin
      px_t p;
      int  a;
      p = pend.pop_front();
      if (p.x >= W || p.y >= H) begin
        model_clipped++;
      end else begin
        a = p.y * W + p.x;
        if (p.compare && !($signed(p.depth) < $signed(model_z[a]))) begin
          model_rejected++;
        end else begin
          model_z[a] = p.depth;
          model_written++;
          found = 1;
          addr  = a;
          depth = p.depth;
          color = p.color;
        end
      end
    end
  endtask

  // Compare process: every cycle checks handshake/commit agreement, stall
  // stability, and each write against the reference model.
  bit          stalled_prev = 0;
  logic [31:0] prev_addr;
  logic [11:0] prev_color;

  always @(negedge clk) begin
    bit          found;
    logic [31:0] ea, ed;
    logic [11:0] ec;
    if (rst) begin
      pend.delete();
      stalled_prev   = 0;
      model_written  = 0;
      model_rejected = 0;
      model_clipped  = 0;
    end else if (mon_en) begin
      checkOutput("zb_wr_en vs handshake", zb_wr_en, fb_wr_valid & fb_wr_ready);
      if (stalled_prev) begin
        checkOutput("stall valid held", fb_wr_valid, 1);
        checkOutput("stall addr held", fb_wr_addr, prev_addr);
        checkOutput("stall color held", fb_wr_color, prev_color);
      end
      if (fb_wr_valid && fb_wr_ready) begin
        model_next_write(found, ea, ed, ec);
        checkOutput("write expected by model", found, 1);
        if (found) begin
          checkOutput("fb_wr_addr", fb_wr_addr, ea);
          checkOutput("fb_wr_color", fb_wr_color, ec);
          checkOutput("zb_wr_addr", zb_wr_addr, ea);
          checkOutput("zb_wr_data", zb_wr_data, ed);
        end
        hs_count++;
        last_hs_addr  = fb_wr_addr;
        last_hs_depth = zb_wr_data;
      end
      stalled_prev = fb_wr_valid && !fb_wr_ready;
      prev_addr    = fb_wr_addr;
      prev_color   = fb_wr_color;
      if (in_valid && in_ready)
        pend.push_back('{x: in_pixel_x, y: in_pixel_y, depth: in_depth,
                         color: in_color, compare: in_compare_depth});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pixel and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                               input logic [31:0] depth, input logic [11:0] color,
                               input logic compare);
    bit accepted;
    in_pixel_x       = x;
    in_pixel_y       = y;
    in_depth         = depth;
    in_color         = color;
    in_compare_depth = compare;
    in_valid         = 1'b1;
    accepted         = 0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept within bound", accepted, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global timeout: actual running required finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int h0;
    bit found;
    logic [31:0] ea, ed;
    logic [11:0] ec;

    for (int i = 0; i < W*H; i++) begin
      zb_mem[i]  = 32'h7FFF_FFFF;
      model_z[i] = 32'h7FFF_FFFF;
    end
    zb_mem[10]  = 32'h0001_0000;
    model_z[10] = 32'h0001_0000;

    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel_x = '0;
    in_pixel_y = '0;
    in_depth = '0;
    in_color = '0;
    in_compare_depth = 1'b0;
    fb_wr_ready = 1'b1;
`ifdef PIXEL_STATS_EN
    stat_clear = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset zb_rd_en", zb_rd_en, 0);
    checkOutput("reset fb_wr_valid", fb_wr_valid, 0);
    checkOutput("reset zb_wr_en", zb_wr_en, 0);
    idle(2);
    rst = 1'b0;
    mon_en = 1;

    // Fill pixel: read one cycle after accept, write the cycle after that
    applyStimulus(16'd3, 16'd2, 32'h7FFF_FFFF, 12'hABC, 1'b0);
    @(negedge clk);
    checkOutput("fill zb_rd_en", zb_rd_en, 1);
    checkOutput("fill zb_rd_addr", zb_rd_addr, 643);
    idle(1);
    @(negedge clk);
    checkOutput("fill fb_wr_valid", fb_wr_valid, 1);
    checkOutput("fill fb_wr_addr", fb_wr_addr, 643);
    checkOutput("fill fb_wr_color", fb_wr_color, 12'hABC);
    checkOutput("fill zb_wr_en", zb_wr_en, 1);
    checkOutput("fill zb_wr_addr", zb_wr_addr, 643);
    checkOutput("fill zb_wr_data", zb_wr_data, 32'h7FFF_FFFF);
    idle(2);

    // Depth compare against zb[10] = 0x00010000
    h0 = hs_count;
    applyStimulus(16'd10, 16'd0, 32'h0002_0000, 12'h111, 1'b1);
    idle(4);
    checkOutput("farther rejected", hs_count - h0, 0);
    applyStimulus(16'd10, 16'd0, 32'h0001_0000, 12'h222, 1'b1);
    idle(4);
    checkOutput("equal rejected", hs_count - h0, 0);
    applyStimulus(16'd10, 16'd0, 32'h0000_8000, 12'h333, 1'b1);
    idle(4);
    checkOutput("nearer written", hs_count - h0, 1);
    checkOutput("nearer depth", last_hs_depth, 32'h0000_8000);

    // Back-to-back same address exercises forwarding
    h0 = hs_count;
    applyStimulus(16'd50, 16'd0, 32'h100, 12'h444, 1'b1);
    applyStimulus(16'd50, 16'd0, 32'h200, 12'h555, 1'b1);
    idle(4);
    checkOutput("fwd near-then-far writes", hs_count - h0, 1);
    checkOutput("fwd near-then-far depth", last_hs_depth, 32'h100);
    h0 = hs_count;
    applyStimulus(16'd51, 16'd0, 32'h200, 12'h666, 1'b1);
    applyStimulus(16'd51, 16'd0, 32'h100, 12'h777, 1'b1);
    idle(4);
    checkOutput("fwd far-then-near writes", hs_count - h0, 2);
    checkOutput("fwd far-then-near depth", last_hs_depth, 32'h100);

    // Framebuffer back-pressure for five cycles
    h0 = hs_count;
    fb_wr_ready = 1'b0;
    applyStimulus(16'd20, 16'd0, 32'd500, 12'h888, 1'b1);
    applyStimulus(16'd20, 16'd0, 32'd600, 12'h999, 1'b1);
    in_pixel_x = 16'd21;
    in_pixel_y = 16'd0;
    in_depth = 32'd400;
    in_color = 12'hAAA;
    in_compare_depth = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall fb_wr_valid", fb_wr_valid, 1);
      checkOutput("stall fb_wr_addr", fb_wr_addr, 20);
      checkOutput("stall zb_wr_en", zb_wr_en, 0);
      checkOutput("stall in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    fb_wr_ready = 1'b1;
    applyStimulus(16'd21, 16'd0, 32'd400, 12'hAAA, 1'b1);
    idle(5);
    checkOutput("after stall writes", hs_count - h0, 2);
    checkOutput("after stall zb[20]", zb_mem[20], 32'd500);
    checkOutput("after stall zb[21]", zb_mem[21], 32'd400);

    // Off-screen pixels: no read, no write
    h0 = hs_count;
    applyStimulus(16'd320, 16'd0, 32'd1, 12'hBBB, 1'b0);
    @(negedge clk);
    checkOutput("clip x zb_rd_en", zb_rd_en, 0);
    checkOutput("clip x busy", busy, 1);
    idle(1);
    applyStimulus(16'd0, 16'd240, 32'd1, 12'hBBB, 1'b0);
    @(negedge clk);
    checkOutput("clip y zb_rd_en", zb_rd_en, 0);
    idle(4);
    checkOutput("clip no writes", hs_count - h0, 0);

    // Reset while stalled drops the pending pixel
    h0 = hs_count;
    fb_wr_ready = 1'b0;
    applyStimulus(16'd30, 16'd0, 32'd1, 12'h005, 1'b0);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst fb_wr_valid", fb_wr_valid, 0);
    checkOutput("rst fb_wr_addr", fb_wr_addr, 0);
    checkOutput("rst fb_wr_color", fb_wr_color, 0);
    checkOutput("rst zb_wr_en", zb_wr_en, 0);
    checkOutput("rst zb_rd_en", zb_rd_en, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst in_ready", in_ready, 0);
    idle(1);
    @(negedge clk);
    checkOutput("rst busy later", busy, 0);
    idle(1);
    rst = 1'b0;
    fb_wr_ready = 1'b1;
    idle(6);
    checkOutput("rst pending dropped", hs_count - h0, 0);
    checkOutput("rst zb[30] untouched", zb_mem[30], 32'h7FFF_FFFF);

    // Randomized traffic with clustered addresses and random back-pressure
    for (int n = 0; n < 3000; n++) begin
      fb_wr_ready      = ($urandom_range(0, 3) != 0);
      in_valid         = ($urandom_range(0, 2) != 0);
      in_pixel_x       = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(318, 322))
                                                     : 16'($urandom_range(0, 7));
      in_pixel_y       = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(238, 241))
                                                     : 16'($urandom_range(0, 2));
      in_depth         = 32'(int'($urandom_range(0, 40)) - 20);
      in_color         = 12'($urandom);
      in_compare_depth = ($urandom_range(0, 3) != 0);
      rst              = (n == 1500 || n == 1501);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    fb_wr_ready = 1'b1;
    idle(10);

    model_next_write(found, ea, ed, ec);
    checkOutput("no lost writes", found, 0);
    checkOutput("busy after drain", busy, 0);

`ifdef PIXEL_STATS_EN
    checkOutput("stat_written", stat_written, model_written);
    checkOutput("stat_rejected", stat_rejected, model_rejected);
    checkOutput("stat_clipped", stat_clipped, model_clipped);
    stat_clear = 1'b1;
    idle(1);
    stat_clear = 1'b0;
    @(negedge clk);
    checkOutput("stat_clear written", stat_written, 0);
    checkOutput("stat_clear clipped", stat_clipped, 0);
`endif

    mon_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
